// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake direction input path.
//   dir_t      - 2-bit direction encoding used by buttons, queue and dir output
//   BTN_*      - bit index of each direction inside the raw button vector
//   opposite() - direction that would reverse the snake onto itself
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Button bit positions match the dir_t encoding, so a button index is
  // directly usable as a direction.
  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int NUM_BUTTONS = 4;

  // UP/DOWN and LEFT/RIGHT differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'd1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: one push-button channel.
//   clock_100Mhz - system clock
//   reset        - asynchronous, active-high reset
//   button       - raw asynchronous button input
//   level        - debounced button level
//   press        - one-cycle pulse, the cycle after level rises
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_out;
  logic [CNT_W-1:0] stable_cnt;
  logic             level_q;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level; any return to agreement restarts it, so only an input
  // that stays changed for DEBOUNCE_CYCLES consecutive cycles flips level.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_out   <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      press      <= 1'b0;
    end else begin
      sync_meta <= button;
      sync_out  <= sync_meta;
      if (sync_out == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST_COUNT) begin
        level      <= ~level;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/snake_dir_input.sv
// snake_dir_input: turns raw buttons into queued turn requests and commits
// one turn per game step.
//   clock_100Mhz - system clock
//   reset        - asynchronous, active-high reset
//   buttons      - raw buttons; bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT
//   step_tick    - one-cycle game step pulse
//   dir          - committed direction (dir_t encoding)
//   dir_changed  - pulses in the cycle dir takes a new value
//   btn_level    - debounced button levels
//   btn_press    - debounced rising-edge pulses
//   q_count      - turn queue occupancy, 0..2
//   drop_count   - saturating count of discarded requests
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         CNT_W           = 20,
  parameter logic [1:0] RESET_DIR       = 2'd3
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic       step_tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [1:0] q_count,
  output logic [7:0] drop_count
);

  dir_t       dir_q;
  dir_t       q_head;
  dir_t       q_second;
  dir_t       dir_n;
  dir_t       q_head_n;
  dir_t       q_second_n;
  logic [1:0] q_count_n;
  logic       req_valid;
  dir_t       req_dir;
  logic [2:0] extra_drops;
  dir_t       tail;
  logic       pop;
  logic       has_space;
  logic       accept;
  logic [2:0] drops_now;
  logic [8:0] drop_sum;
  logic [7:0] drop_n;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clock_100Mhz(clock_100Mhz),
      .reset       (reset),
      .button      (buttons[i]),
      .level       (btn_level[i]),
      .press       (btn_press[i])
    );
  end

  // Lowest set press bit wins; every other bit pressed in the same cycle is
  // lost and counted as a drop.
  always_comb begin
    req_valid   = 1'b0;
    req_dir     = DIR_UP;
    extra_drops = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (btn_press[i]) begin
        if (!req_valid) begin
          req_valid = 1'b1;
          req_dir   = dir_t'(i[1:0]);
        end else begin
          extra_drops = extra_drops + 3'd1;
        end
      end
    end
  end

  // A request is judged against the direction the snake will have after
  // everything already queued, so both repeats and reversals of the newest
  // queued turn are rejected. A full queue still accepts when a tick frees
  // the head slot this cycle.
  always_comb begin
    tail      = (q_count == 2'd2) ? q_second : (q_count == 2'd1) ? q_head : dir_q;
    pop       = step_tick && (q_count != 2'd0);
    has_space = (q_count != 2'd2) || pop;
    accept    = req_valid && (req_dir != tail) && (req_dir != opposite(tail)) && has_space;
    drops_now = extra_drops + {2'b00, (req_valid && !accept)};
    drop_sum  = {1'b0, drop_count} + {6'd0, drops_now};
    drop_n    = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Queue shift: a pop moves the second slot to the head; a push lands in
  // the first slot that is free once the pop has happened.
  always_comb begin
    dir_n      = dir_q;
    q_head_n   = q_head;
    q_second_n = q_second;
    q_count_n  = q_count;
    if (pop) begin
      dir_n    = q_head;
      q_head_n = q_second;
    end
    case ({pop, accept})
      2'b10: q_count_n = q_count - 2'd1;
      2'b01: begin
        if (q_count == 2'd0) q_head_n = req_dir;
        else                 q_second_n = req_dir;
        q_count_n = q_count + 2'd1;
      end
      2'b11: begin
        if (q_count == 2'd1) q_head_n = req_dir;
        else                 q_second_n = req_dir;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      dir_q       <= dir_t'(RESET_DIR);
      q_head      <= DIR_UP;
      q_second    <= DIR_UP;
      q_count     <= 2'd0;
      dir_changed <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      dir_q       <= dir_n;
      q_head      <= q_head_n;
      q_second    <= q_second_n;
      q_count     <= q_count_n;
      dir_changed <= pop;
      drop_count  <= drop_n;
    end
  end

  assign dir = dir_q;

endmodule
